n101_icb_line_fetch: RTL and testbench

ICB read master that refills one instruction-cache line from the ICB SRAM slave (`n101_icb_ram_top`) sitting directly downstream. On a line request it issues LINE_WORDS single-word ICB reads, starting critical word first and wrapping within the line. Up to OUTS reads are kept in flight, and each returned word is forwarded to the cache fill port as an indexed beat.

---
 rtl/n101_icb_line_fetch_pkg.sv | 20 ++
 rtl/n101_icb_line_fetch_dff.sv | 20 ++
 rtl/n101_icb_line_fetch.sv | 153 +++++++++++++++
 tb/tb_n101_icb_line_fetch.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/n101_icb_line_fetch_pkg.sv
// Shared n101 line-fetch definitions: FSM encoding and helpers for derived widths.
// The cache controller imports this package as well.
package n101_icb_line_fetch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Outstanding counter must hold 0..4.
    localparam int OUT_W = 3;

    function automatic int idx_width(input int words);
        return $clog2(words);
    endfunction

    function automatic int ofs_width(input int words);
        return $clog2(words) + 2;
    endfunction

endpackage

// File: rtl/n101_icb_line_fetch_dff.sv
// General load-enable flop cell with synchronous active-low reset to zero.
module n101_gnrl_dfflr #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            qout <= '0;
        end else if (lden) begin
            qout <= dnxt;
        end
    end

endmodule

// File: rtl/n101_icb_line_fetch.sv
// ICB read master refilling one I-cache line, critical word first with wrap,
// keeping up to OUTS reads in flight and forwarding responses as indexed beats.
module n101_icb_line_fetch
    import n101_icb_line_fetch_pkg::*;
#(
    parameter int AW         = 12,
    parameter int DW         = 32,
    parameter int LINE_WORDS = 4,
    parameter int OUTS       = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [AW-1:0]                       req_addr,
    output logic                                beat_valid,
    input  logic                                beat_ready,
    output logic [DW-1:0]                       beat_data,
    output logic [idx_width(LINE_WORDS)-1:0]    beat_idx,
    output logic                                beat_err,
    output logic                                beat_last,
    output logic                                busy,
    output logic                                icb_cmd_valid,
    input  logic                                icb_cmd_ready,
    output logic                                icb_cmd_read,
    output logic [AW-1:0]                       icb_cmd_addr,
    output logic [DW-1:0]                       icb_cmd_wdata,
    output logic [DW/8-1:0]                     icb_cmd_wmask,
    input  logic                                icb_rsp_valid,
    output logic                                icb_rsp_ready,
    input  logic [DW-1:0]                       icb_rsp_rdata,
    input  logic                                icb_rsp_err
);

    localparam int IDX_W  = idx_width(LINE_WORDS);
    localparam int OFS_W  = ofs_width(LINE_WORDS);
    localparam int LINE_W = AW - OFS_W;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [IDX_W:0]   cnt_t;
    typedef logic [OUT_W-1:0] out_t;

    localparam cnt_t LAST_CNT = cnt_t'(LINE_WORDS - 1);
    localparam out_t OUTS_MAX = out_t'(OUTS);

    logic [1:0]        state_q, state_d;
    logic [LINE_W-1:0] line_q, line_d;
    idx_t              cmd_idx_q, cmd_idx_d;
    idx_t              beat_idx_q, beat_idx_d;
    out_t              outst_q, outst_d;
    cnt_t              cmd_cnt_q, cmd_cnt_d;
    cnt_t              rsp_cnt_q, rsp_cnt_d;

    logic active;
    logic req_hs;
    logic cmd_hs;
    logic rsp_hs;
    logic unused_addr_lsb;

    assign active          = (state_q != ST_IDLE);
    assign req_ready       = (state_q == ST_IDLE);
    assign busy            = active;
    assign req_hs          = req_valid && req_ready;

    // A response retiring this cycle does not open a slot until the next one.
    assign icb_cmd_valid   = (state_q == ST_FETCH) && (outst_q < OUTS_MAX);
    assign cmd_hs          = icb_cmd_valid && icb_cmd_ready;
    assign icb_cmd_read    = 1'b1;
    assign icb_cmd_addr    = {line_q, cmd_idx_q, 2'b00};
    assign icb_cmd_wdata   = '0;
    assign icb_cmd_wmask   = '0;

    assign icb_rsp_ready   = beat_ready && active;
    assign beat_valid      = icb_rsp_valid && active;
    assign rsp_hs          = icb_rsp_valid && icb_rsp_ready;
    assign beat_data       = icb_rsp_rdata;
    assign beat_err        = icb_rsp_err;
    assign beat_idx        = beat_idx_q;
    assign beat_last       = (rsp_cnt_q == LAST_CNT);

    assign unused_addr_lsb = ^req_addr[1:0];

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        cmd_idx_d  = cmd_hs ? cmd_idx_q + 1'b1 : cmd_idx_q;
        cmd_cnt_d  = cmd_hs ? cmd_cnt_q + 1'b1 : cmd_cnt_q;
        beat_idx_d = rsp_hs ? beat_idx_q + 1'b1 : beat_idx_q;
        rsp_cnt_d  = rsp_hs ? rsp_cnt_q + 1'b1 : rsp_cnt_q;
        outst_d    = outst_q;
        if (cmd_hs && !rsp_hs) begin
            outst_d = outst_q + 1'b1;
        end else if (!cmd_hs && rsp_hs) begin
            outst_d = outst_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_hs) begin
                    state_d    = ST_FETCH;
                    line_d     = req_addr[AW-1:OFS_W];
                    cmd_idx_d  = req_addr[OFS_W-1:2];
                    beat_idx_d = req_addr[OFS_W-1:2];
                    cmd_cnt_d  = '0;
                    rsp_cnt_d  = '0;
                    outst_d    = '0;
                end
            end
            ST_FETCH: begin
                if (cmd_hs && (cmd_cnt_q == LAST_CNT)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (rsp_hs && (rsp_cnt_q == LAST_CNT)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    n101_gnrl_dfflr #(.DW(2)) u_state_dff (
        .clk(clk), .rst_n(rst_n), .lden(1'b1), .dnxt(state_d), .qout(state_q)
    );

    n101_gnrl_dfflr #(.DW(LINE_W)) u_line_dff (
        .clk(clk), .rst_n(rst_n), .lden(1'b1), .dnxt(line_d), .qout(line_q)
    );

    n101_gnrl_dfflr #(.DW(IDX_W)) u_cmd_idx_dff (
        .clk(clk), .rst_n(rst_n), .lden(1'b1), .dnxt(cmd_idx_d), .qout(cmd_idx_q)
    );

    n101_gnrl_dfflr #(.DW(IDX_W)) u_beat_idx_dff (
        .clk(clk), .rst_n(rst_n), .lden(1'b1), .dnxt(beat_idx_d), .qout(beat_idx_q)
    );

    n101_gnrl_dfflr #(.DW(OUT_W)) u_outst_dff (
        .clk(clk), .rst_n(rst_n), .lden(1'b1), .dnxt(outst_d), .qout(outst_q)
    );

    n101_gnrl_dfflr #(.DW(IDX_W+1)) u_cmd_cnt_dff (
        .clk(clk), .rst_n(rst_n), .lden(1'b1), .dnxt(cmd_cnt_d), .qout(cmd_cnt_q)
    );

    n101_gnrl_dfflr #(.DW(IDX_W+1)) u_rsp_cnt_dff (
        .clk(clk), .rst_n(rst_n), .lden(1'b1), .dnxt(rsp_cnt_d), .qout(rsp_cnt_q)
    );

endmodule

// File: tb/tb_n101_icb_line_fetch.sv
// Bench for n101_icb_line_fetch: a queue-based 1-cycle SRAM slave, a beat/command
// monitor, and a line-order reference model built from base/start-index arithmetic.
module tb_n101_icb_line_fetch;

    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int LW   = 4;
    localparam int OUTS = 2;
    localparam int IW   = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [AW-1:0]   req_addr = '0;
    logic            beat_valid;
    logic            beat_ready = 1'b1;
    logic [DW-1:0]   beat_data;
    logic [IW-1:0]   beat_idx;
    logic            beat_err;
    logic            beat_last;
    logic            busy;
    logic            icb_cmd_valid;
    logic            icb_cmd_ready;
    logic            icb_cmd_read;
    logic [AW-1:0]   icb_cmd_addr;
    logic [DW-1:0]   icb_cmd_wdata;
    logic [DW/8-1:0] icb_cmd_wmask;
    logic            icb_rsp_valid;
    logic            icb_rsp_ready;
    logic [DW-1:0]   icb_rsp_rdata;
    logic            icb_rsp_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int br_mode = 0;
    int cr_mode = 0;
    logic cmd_gate = 1'b1;
    logic err_en = 1'b0;
    logic [AW-1:0] err_addr = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    n101_icb_line_fetch #(.AW(AW), .DW(DW), .LINE_WORDS(LW), .OUTS(OUTS)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_data(beat_data),
        .beat_idx(beat_idx), .beat_err(beat_err), .beat_last(beat_last), .busy(busy),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_read(icb_cmd_read), .icb_cmd_addr(icb_cmd_addr),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err)
    );

    // SRAM slave: one cycle read latency, buffers up to 3 responses.
    typedef struct { logic [DW-1:0] d; logic e; } srsp_t;
    srsp_t sq[$];
    logic [DW-1:0] mem [0:1023];
    logic s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic s_err = 1'b0;
    int s_cnt = 0;

    assign icb_cmd_ready = cmd_gate && (s_cnt < 3);
    assign icb_rsp_valid = s_valid;
    assign icb_rsp_rdata = s_data;
    assign icb_rsp_err   = s_err;

    always @(posedge clk) begin
        if (!rst_n) begin
            sq.delete();
        end else begin
            if (icb_rsp_valid && icb_rsp_ready) void'(sq.pop_front());
            if (icb_cmd_valid && icb_cmd_ready)
                sq.push_back('{mem[icb_cmd_addr[AW-1:2]], err_en && (icb_cmd_addr == err_addr)});
        end
        s_valid <= (sq.size() > 0);
        s_data  <= (sq.size() > 0) ? sq[0].d : '0;
        s_err   <= (sq.size() > 0) ? sq[0].e : 1'b0;
        s_cnt   <= sq.size();
    end

    typedef struct { logic [DW-1:0] data; logic [IW-1:0] idx; logic err; logic last; int cyc; } beat_t;
    beat_t beat_q[$];
    logic [AW-1:0] cmd_addr_q[$];
    int cmd_cyc_q[$];
    int outst = 0;
    int max_outst = 0;
    int mirror_bad = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            outst = 0;
        end else begin
            if (beat_valid && beat_ready) beat_q.push_back('{beat_data, beat_idx, beat_err, beat_last, cyc});
            if (icb_cmd_valid && icb_cmd_ready) begin
                cmd_addr_q.push_back(icb_cmd_addr);
                cmd_cyc_q.push_back(cyc);
            end
            outst = outst + ((icb_cmd_valid && icb_cmd_ready) ? 1 : 0)
                          - ((icb_rsp_valid && icb_rsp_ready) ? 1 : 0);
            if (outst > max_outst) max_outst = outst;
            if (icb_rsp_ready !== (beat_ready && busy)) mirror_bad++;
        end
    end

    // Reference model: k-th word of the line starting at the missed word, wrapping.
    function automatic int exp_idx(input logic [AW-1:0] a, input int k);
        int ai;
        ai = int'(a);
        return ((ai / 4) % LW + k) % LW;
    endfunction

    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] a, input int k);
        int ai;
        ai = int'(a);
        return AW'((ai / (LW * 4)) * (LW * 4) + exp_idx(a, k) * 4);
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a, input int k);
        logic [AW-1:0] ea;
        ea = exp_addr(a, k);
        return mem[ea[AW-1:2]];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        case (br_mode)
            0:       beat_ready = 1'b1;
            1:       beat_ready = !beat_ready;
            default: beat_ready = 1'($urandom_range(0, 1));
        endcase
        if (cr_mode == 0) cmd_gate = 1'b1;
        else if (cr_mode == 1) cmd_gate = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_req(input logic [AW-1:0] a, output int hs_cyc, output bit ok);
        ok = 0;
        hs_cyc = 0;
        req_addr = a;
        req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                hs_cyc = cyc;
                ok = 1;
                step();
                req_valid = 1'b0;
                return;
            end
            step();
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok, output int idle_cyc);
        ok = 0;
        idle_cyc = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) begin
                idle_cyc = cyc;
                ok = 1;
                step();
                return;
            end
            step();
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (icb_cmd_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_cmd_valid got=%b exp=0", icb_cmd_valid); end
        checks++; if (beat_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_beat_valid got=%b exp=0", beat_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (beat_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_beat_last got=%b exp=0", beat_last); end
        checks++; if (icb_rsp_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_ready got=%b exp=0", icb_rsp_ready); end
        step();
    endtask

    task automatic test_basic();
        logic [AW-1:0] exp_cmd [LW];
        int exp_i [LW];
        int c0, b0, hs, idle;
        bit ok_r, ok_i;
        exp_cmd = '{12'h104, 12'h108, 12'h10C, 12'h100};
        exp_i = '{1, 2, 3, 0};
        br_mode = 0; cr_mode = 0;
        c0 = cmd_addr_q.size(); b0 = beat_q.size();
        send_req(12'h104, hs, ok_r);
        wait_idle(ok_i, idle);
        checks++; if (!ok_r || !ok_i) begin failures++; $display("[TB] FAIL basic_timeout req=%0d idle=%0d exp=1/1", ok_r, ok_i); end
        checks++;
        if (cmd_addr_q.size() - c0 != LW || beat_q.size() - b0 != LW) begin
            failures++;
            $display("[TB] FAIL basic_count cmds=%0d beats=%0d exp=%0d", cmd_addr_q.size() - c0, beat_q.size() - b0, LW);
        end else begin
            for (int k = 0; k < LW; k++) begin
                checks++; if (cmd_addr_q[c0+k] !== exp_cmd[k]) begin failures++; $display("[TB] FAIL basic_cmd_addr[%0d] got=%h exp=%h", k, cmd_addr_q[c0+k], exp_cmd[k]); end
                checks++; if (beat_q[b0+k].idx !== IW'(exp_i[k])) begin failures++; $display("[TB] FAIL basic_idx[%0d] got=%0d exp=%0d", k, beat_q[b0+k].idx, exp_i[k]); end
                checks++; if (beat_q[b0+k].last !== (k == LW - 1)) begin failures++; $display("[TB] FAIL basic_last[%0d] got=%b exp=%b", k, beat_q[b0+k].last, k == LW - 1); end
                checks++; if (beat_q[b0+k].data !== mem[exp_cmd[k][AW-1:2]]) begin failures++; $display("[TB] FAIL basic_data[%0d] got=%h exp=%h", k, beat_q[b0+k].data, mem[exp_cmd[k][AW-1:2]]); end
            end
            checks++; if (beat_q[b0].cyc != hs + 2) begin failures++; $display("[TB] FAIL basic_first_beat_cyc got=%0d exp=%0d", beat_q[b0].cyc, hs + 2); end
            checks++; if (beat_q[b0+LW-1].cyc != hs + LW + 1) begin failures++; $display("[TB] FAIL basic_last_beat_cyc got=%0d exp=%0d", beat_q[b0+LW-1].cyc, hs + LW + 1); end
        end
        checks++; if (idle != hs + LW + 2) begin failures++; $display("[TB] FAIL basic_idle_cyc got=%0d exp=%0d", idle, hs + LW + 2); end
    endtask

    task automatic test_cmd_stall();
        logic [AW-1:0] a;
        int c0, b0, hs, idle;
        bit ok_r, ok_i, seen;
        a = 12'h0A8;
        br_mode = 0; cr_mode = 2; cmd_gate = 1'b1;
        c0 = cmd_addr_q.size(); b0 = beat_q.size();
        send_req(a, hs, ok_r);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_addr_q.size() - c0 >= 1) begin seen = 1; break; end
            step();
        end
        checks++; if (!seen) begin failures++; $display("[TB] FAIL stall_first_cmd got=0 exp=1"); end
        cmd_gate = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (icb_cmd_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_valid_held[%0d] got=%b exp=1", i, icb_cmd_valid); end
            checks++; if (icb_cmd_addr !== exp_addr(a, 1)) begin failures++; $display("[TB] FAIL stall_addr_held[%0d] got=%h exp=%h", i, icb_cmd_addr, exp_addr(a, 1)); end
            step();
        end
        cmd_gate = 1'b1;
        cr_mode = 0;
        wait_idle(ok_i, idle);
        checks++; if (!ok_r || !ok_i) begin failures++; $display("[TB] FAIL stall_timeout req=%0d idle=%0d exp=1/1", ok_r, ok_i); end
        checks++; if (max_outst > OUTS) begin failures++; $display("[TB] FAIL stall_outstanding got=%0d exp<=%0d", max_outst, OUTS); end
        checks++;
        if (beat_q.size() - b0 != LW) begin
            failures++; $display("[TB] FAIL stall_beat_count got=%0d exp=%0d", beat_q.size() - b0, LW);
        end else begin
            for (int k = 0; k < LW; k++) begin
                checks++; if (beat_q[b0+k].idx !== IW'(exp_idx(a, k)) || beat_q[b0+k].data !== exp_data(a, k)) begin
                    failures++; $display("[TB] FAIL stall_beat[%0d] got=%0d/%h exp=%0d/%h", k, beat_q[b0+k].idx, beat_q[b0+k].data, exp_idx(a, k), exp_data(a, k));
                end
            end
        end
    endtask

    task automatic test_beat_backpressure();
        int b0, hs, idle, mb0;
        bit ok_r, ok_i;
        beat_ready = 1'b1; br_mode = 1; cr_mode = 0;
        b0 = beat_q.size(); mb0 = mirror_bad;
        send_req(12'h300, hs, ok_r);
        wait_idle(ok_i, idle);
        br_mode = 0;
        checks++; if (!ok_r || !ok_i) begin failures++; $display("[TB] FAIL bp_timeout req=%0d idle=%0d exp=1/1", ok_r, ok_i); end
        checks++; if (mirror_bad != mb0) begin failures++; $display("[TB] FAIL bp_rsp_ready_mirror got=%0d exp=0 mismatching cycles", mirror_bad - mb0); end
        checks++;
        if (beat_q.size() - b0 != LW) begin
            failures++; $display("[TB] FAIL bp_beat_count got=%0d exp=%0d", beat_q.size() - b0, LW);
        end else begin
            for (int k = 0; k < LW; k++) begin
                checks++; if (beat_q[b0+k].data !== DW'(32'hA0 + k) || beat_q[b0+k].idx !== IW'(k)) begin
                    failures++; $display("[TB] FAIL bp_beat[%0d] got=%0d/%h exp=%0d/%h", k, beat_q[b0+k].idx, beat_q[b0+k].data, k, 32'hA0 + k);
                end
            end
        end
    endtask

    task automatic test_error();
        int b0, hs, idle;
        bit ok_r, ok_i;
        br_mode = 0; cr_mode = 0;
        err_en = 1'b1; err_addr = 12'h148;
        b0 = beat_q.size();
        send_req(12'h140, hs, ok_r);
        wait_idle(ok_i, idle);
        err_en = 1'b0;
        checks++; if (!ok_r || !ok_i) begin failures++; $display("[TB] FAIL err_timeout req=%0d idle=%0d exp=1/1", ok_r, ok_i); end
        checks++;
        if (beat_q.size() - b0 != LW) begin
            failures++; $display("[TB] FAIL err_beat_count got=%0d exp=%0d", beat_q.size() - b0, LW);
        end else begin
            for (int k = 0; k < LW; k++) begin
                checks++; if (beat_q[b0+k].err !== (k == 2)) begin failures++; $display("[TB] FAIL err_flag[%0d] got=%b exp=%b", k, beat_q[b0+k].err, k == 2); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int c0, b0, hs, idle;
        bit ok_r, ok_i, seen;
        br_mode = 0; cr_mode = 0;
        c0 = cmd_addr_q.size();
        send_req(12'h080, hs, ok_r);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_addr_q.size() - c0 >= 2) begin seen = 1; break; end
            step();
        end
        checks++; if (!seen) begin failures++; $display("[TB] FAIL rstmid_two_cmds got=0 exp=1"); end
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_req_ready got=%b exp=1", req_ready); end
        checks++; if (icb_cmd_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_cmd_valid got=%b exp=0", icb_cmd_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (beat_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_beat_valid got=%b exp=0", beat_valid); end
        step();
        c0 = cmd_addr_q.size(); b0 = beat_q.size();
        send_req(12'h200, hs, ok_r);
        wait_idle(ok_i, idle);
        checks++; if (!ok_r || !ok_i) begin failures++; $display("[TB] FAIL rstmid_fresh_timeout req=%0d idle=%0d exp=1/1", ok_r, ok_i); end
        checks++;
        if (cmd_addr_q.size() - c0 != LW || beat_q.size() - b0 != LW) begin
            failures++; $display("[TB] FAIL rstmid_fresh_count cmds=%0d beats=%0d exp=%0d", cmd_addr_q.size() - c0, beat_q.size() - b0, LW);
        end else begin
            for (int k = 0; k < LW; k++) begin
                checks++; if (cmd_addr_q[c0+k] !== exp_addr(12'h200, k) || beat_q[b0+k].data !== exp_data(12'h200, k)) begin
                    failures++; $display("[TB] FAIL rstmid_fresh[%0d] got=%h/%h exp=%h/%h", k, cmd_addr_q[c0+k], beat_q[b0+k].data, exp_addr(12'h200, k), exp_data(12'h200, k));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] a, b;
        int c0, b0, hs_a, hs_b, idle;
        bit ok_r, ok_i, got;
        a = 12'h1F8; b = 12'h234;
        br_mode = 0; cr_mode = 0;
        c0 = cmd_addr_q.size(); b0 = beat_q.size();
        send_req(a, hs_a, ok_r);
        req_addr = b;
        req_valid = 1'b1;
        got = 0; hs_b = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) begin hs_b = cyc; got = 1; step(); req_valid = 1'b0; break; end
            step();
        end
        req_valid = 1'b0;
        wait_idle(ok_i, idle);
        checks++; if (!ok_r || !got || !ok_i) begin failures++; $display("[TB] FAIL b2b_timeout a=%0d b=%0d idle=%0d exp=1/1/1", ok_r, got, ok_i); end
        checks++; if (hs_b != hs_a + LW + 2) begin failures++; $display("[TB] FAIL b2b_second_accept_cyc got=%0d exp=%0d", hs_b, hs_a + LW + 2); end
        checks++;
        if (cmd_addr_q.size() - c0 != 2 * LW || beat_q.size() - b0 != 2 * LW) begin
            failures++; $display("[TB] FAIL b2b_count cmds=%0d beats=%0d exp=%0d", cmd_addr_q.size() - c0, beat_q.size() - b0, 2 * LW);
        end else begin
            checks++; if (hs_b != beat_q[b0+LW-1].cyc + 1) begin failures++; $display("[TB] FAIL b2b_after_last_beat got=%0d exp=%0d", hs_b, beat_q[b0+LW-1].cyc + 1); end
            checks++; if (!(cmd_cyc_q[c0+LW-1] < hs_b && cmd_cyc_q[c0+LW] > hs_b)) begin
                failures++; $display("[TB] FAIL b2b_cmd_overlap got=%0d,%0d exp=<%0d,>%0d", cmd_cyc_q[c0+LW-1], cmd_cyc_q[c0+LW], hs_b, hs_b);
            end
            for (int k = 0; k < LW; k++) begin
                checks++; if (cmd_addr_q[c0+LW+k] !== exp_addr(b, k) || beat_q[b0+LW+k].idx !== IW'(exp_idx(b, k))) begin
                    failures++; $display("[TB] FAIL b2b_line_b[%0d] got=%h/%0d exp=%h/%0d", k, cmd_addr_q[c0+LW+k], beat_q[b0+LW+k].idx, exp_addr(b, k), exp_idx(b, k));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        int c0, b0, hs, idle, ek;
        bit ok_r, ok_i;
        for (int n = 0; n < 25; n++) begin
            a = AW'($urandom);
            br_mode = $urandom_range(0, 2);
            cr_mode = $urandom_range(0, 1);
            ek = $urandom_range(0, LW);
            err_en = (ek < LW);
            err_addr = exp_addr(a, ek % LW);
            c0 = cmd_addr_q.size(); b0 = beat_q.size();
            send_req(a, hs, ok_r);
            wait_idle(ok_i, idle);
            checks++; if (!ok_r || !ok_i) begin failures++; $display("[TB] FAIL rand%0d_timeout req=%0d idle=%0d exp=1/1", n, ok_r, ok_i); end
            checks++;
            if (cmd_addr_q.size() - c0 != LW || beat_q.size() - b0 != LW) begin
                failures++; $display("[TB] FAIL rand%0d_count cmds=%0d beats=%0d exp=%0d", n, cmd_addr_q.size() - c0, beat_q.size() - b0, LW);
            end else begin
                for (int k = 0; k < LW; k++) begin
                    checks++;
                    if (cmd_addr_q[c0+k] !== exp_addr(a, k) || beat_q[b0+k].idx !== IW'(exp_idx(a, k)) ||
                        beat_q[b0+k].data !== exp_data(a, k) || beat_q[b0+k].err !== (ek == k) ||
                        beat_q[b0+k].last !== (k == LW - 1)) begin
                        failures++;
                        $display("[TB] FAIL rand%0d_beat[%0d] addr=%h idx=%0d data=%h err=%b last=%b exp addr=%h idx=%0d data=%h err=%b last=%b",
                                 n, k, cmd_addr_q[c0+k], beat_q[b0+k].idx, beat_q[b0+k].data, beat_q[b0+k].err, beat_q[b0+k].last,
                                 exp_addr(a, k), exp_idx(a, k), exp_data(a, k), ek == k, k == LW - 1);
                    end
                end
            end
        end
        err_en = 1'b0; br_mode = 0; cr_mode = 0;
        step();
        checks++; if (max_outst > OUTS) begin failures++; $display("[TB] FAIL rand_outstanding got=%0d exp<=%0d", max_outst, OUTS); end
        checks++; if (mirror_bad != 0) begin failures++; $display("[TB] FAIL rand_rsp_ready_mirror got=%0d exp=0", mirror_bad); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        for (int i = 0; i < LW; i++) mem[(12'h300 >> 2) + i] = DW'(32'hA0 + i);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_basic();
        test_cmd_stall();
        test_beat_backpressure();
        test_error();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
